// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GNT_IF  = 2'b01,
    ARB_GNT_MEM = 2'b10
  } arb_state_e;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  // Positions of the IF and MEM hold bits inside the ctrl stall vector.
  localparam int STALL_IF_BIT  = 1;
  localparam int STALL_MEM_BIT = 4;

  // Timeout counter width: wide enough for the limit, never narrower than 8 bits.
  function automatic int tmo_cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_result_hold.sv
// Per-stage result holder: captures the completed read data, raises done, and
// drops done once the owning stage advances (its stall bit is low).
module mem_bus_arbiter_result_hold
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          stall_i,
  output logic          done_o,
  output logic [DW-1:0] rdata_o
);

  logic          done_q;
  logic [DW-1:0] rdata_q;

  // Load has priority; a grant is never issued while done is set, so load and
  // clear cannot collide in practice.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else if (load_i) begin
      done_q  <= 1'b1;
      rdata_q <= data_i;
    end else if (done_q && !stall_i) begin
      done_q  <= 1'b0;
    end
  end

  assign done_o  = done_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between IF (fetch) and MEM (load/store).
// MEM has fixed priority. Optional abort-on-timeout is enabled by defining
// ARB_TIMEOUT_EN; without it a granted transaction waits for ack forever.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            stallreq_if,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW/8-1:0] mem_sel,
  input  logic [DW-1:0]   mem_wdata,
  output logic [DW-1:0]   mem_rdata,
  output logic            stallreq_mem,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW/8-1:0] bus_sel,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ack,
  output logic            timeout
);

  localparam int SW = DW / 8;

  arb_state_e    state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [SW-1:0] bus_sel_q, bus_sel_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic          if_done, mem_done;
  logic          if_load, mem_load;
  logic [DW-1:0] load_data;
  logic          abort;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

`ifdef ARB_TIMEOUT_EN
  localparam int TW = tmo_cnt_width(TIMEOUT);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q;

  // Down-counter: preset while idle, counts grant cycles; terminal count is zero.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ARB_IDLE) begin
      tmo_cnt_d = TW'(TIMEOUT - 1);
    end else if (tmo_cnt_q != '0) begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end
  end

  assign abort = (state_q != ARB_IDLE) && !bus_ack && (tmo_cnt_q == '0);

  // Counter register and one-cycle timeout pulse aligned with the result load.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      tmo_cnt_q <= TW'(TIMEOUT - 1);
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= abort;
    end
  end

  assign timeout = timeout_q;
`else
  localparam int unused_timeout_limit = TIMEOUT;
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Grant selection, command capture on grant, completion on ack or abort.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    if_load     = 1'b0;
    mem_load    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (mem_req && !mem_done) begin
          state_d     = ARB_GNT_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_sel_d   = mem_sel;
          bus_wdata_d = mem_wdata;
        end else if (if_req && !if_done) begin
          state_d     = ARB_GNT_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_sel_d   = '1;
          bus_wdata_d = '0;
        end
      end
      ARB_GNT_IF: begin
        if (bus_ack || abort) begin
          if_load   = 1'b1;
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
        end
      end
      ARB_GNT_MEM: begin
        if (bus_ack || abort) begin
          mem_load  = 1'b1;
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  assign load_data = abort ? '0 : bus_rdata;

  // FSM state and registered bus command.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  mem_bus_arbiter_result_hold #(.DW(DW)) u_if_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (if_load),
    .data_i  (load_data),
    .stall_i (stall[STALL_IF_BIT]),
    .done_o  (if_done),
    .rdata_o (if_rdata)
  );

  mem_bus_arbiter_result_hold #(.DW(DW)) u_mem_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (mem_load),
    .data_i  (load_data),
    .stall_i (stall[STALL_MEM_BIT]),
    .done_o  (mem_done),
    .rdata_o (mem_rdata)
  );

  assign stallreq_if  = (if_req  && !if_done)  ? STOP : NO_STOP;
  assign stallreq_mem = (mem_req && !mem_done) ? STOP : NO_STOP;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

endmodule
